// File: rtl/slc_sf_arb.sv
// slc_sf_arb: response-priority arbiter with request starvation guard,
// feeding a single-entry issue register in front of the SLC/SF lookup port.

package slc_sf_arb_pkg;

  typedef struct packed {
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [15:0] addr;
    logic        ExpCompAck;
  } reqflit_t;

  typedef struct packed {
    logic [7:0] txn_id;
    logic [3:0] opcode;
    logic [7:0] dbid;
  } rspflit_t;

endpackage

module slc_sf_arb
  import slc_sf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  reqflit_t         req_flit,
  output logic             req_ready,
  input  logic             rsp_valid,
  input  rspflit_t         rsp_flit,
  output logic             rsp_ready,
  input  logic             pocq_full,
  output logic             out_valid,
  output logic             out_sel,
  output reqflit_t         out_req,
  output rspflit_t         out_rsp,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt_req,
  output logic [CNT_W-1:0] grant_cnt_rsp
);

  localparam int              SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  typedef enum logic {
    RSP_PRI = 1'b0,
    REQ_PRI = 1'b1
  } arb_state_t;

  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;
  arb_state_t      state;
  logic            can_load;
  logic            req_elig;
  logic            rsp_elig;
  logic            gnt_req;
  logic            gnt_rsp;

  // Starvation counter register; the arbitration state is derived from it.
  always_ff @(posedge clock) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= starve_nxt;
  end

  // Next starvation count: clear when the request wins or is not contending,
  // count lost contests saturating at the limit, otherwise hold.
  always_comb begin
    starve_nxt = starve_cnt;
    if (gnt_req || !req_elig)
      starve_nxt = '0;
    else if (gnt_rsp && can_load)
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + SC_W'(1);
  end

  // Eligibility, priority state and grants; reset suppresses both grants.
  always_comb begin
    can_load  = !out_valid || out_ready;
    req_elig  = req_valid && !(req_flit.ExpCompAck && pocq_full);
    rsp_elig  = rsp_valid;
    state     = (starve_cnt == LIMIT) ? REQ_PRI : RSP_PRI;
    gnt_rsp   = !reset && can_load && rsp_elig && (!req_elig || state == RSP_PRI);
    gnt_req   = !reset && can_load && req_elig && !gnt_rsp;
    req_ready = gnt_req;
    rsp_ready = gnt_rsp;
  end

  // Issue register: load the winner, or drain when taken with no new grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_req   <= '0;
      out_rsp   <= '0;
    end else if (gnt_req) begin
      out_valid <= 1'b1;
      out_sel   <= 1'b0;
      out_req   <= req_flit;
    end else if (gnt_rsp) begin
      out_valid <= 1'b1;
      out_sel   <= 1'b1;
      out_rsp   <= rsp_flit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Wrapping grant performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt_req <= '0;
      grant_cnt_rsp <= '0;
    end else begin
      if (gnt_req) grant_cnt_req <= grant_cnt_req + CNT_W'(1);
      if (gnt_rsp) grant_cnt_rsp <= grant_cnt_rsp + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_slc_sf_arb.sv
// tb_slc_sf_arb: directed checks of slc_sf_arb with hand-computed expectations.
// A second instance with 4-bit counters shares the stimulus for wrap checks.

module tb_slc_sf_arb;
  import slc_sf_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  reqflit_t    req_flit;
  logic        req_ready;
  logic        rsp_valid;
  rspflit_t    rsp_flit;
  logic        rsp_ready;
  logic        pocq_full;
  logic        out_valid;
  logic        out_sel;
  reqflit_t    out_req;
  rspflit_t    out_rsp;
  logic        out_ready;
  logic [15:0] grant_cnt_req;
  logic [15:0] grant_cnt_rsp;

  logic        n_req_ready, n_rsp_ready, n_out_valid, n_out_sel;
  reqflit_t    n_out_req;
  rspflit_t    n_out_rsp;
  logic [3:0]  n_cnt_req, n_cnt_rsp;

  int numChecks = 0;
  int numPass   = 0;

  reqflit_t rq_a, rq_b;
  rspflit_t rs_a, rs_b;

  slc_sf_arb #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_flit(rsp_flit), .rsp_ready(rsp_ready),
    .pocq_full(pocq_full),
    .out_valid(out_valid), .out_sel(out_sel), .out_req(out_req), .out_rsp(out_rsp),
    .out_ready(out_ready),
    .grant_cnt_req(grant_cnt_req), .grant_cnt_rsp(grant_cnt_rsp)
  );

  slc_sf_arb #(.STARVE_LIMIT(4), .CNT_W(4)) dutn (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_flit(req_flit), .req_ready(n_req_ready),
    .rsp_valid(rsp_valid), .rsp_flit(rsp_flit), .rsp_ready(n_rsp_ready),
    .pocq_full(pocq_full),
    .out_valid(n_out_valid), .out_sel(n_out_sel), .out_req(n_out_req), .out_rsp(n_out_rsp),
    .out_ready(out_ready),
    .grant_cnt_req(n_cnt_req), .grant_cnt_rsp(n_cnt_rsp)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    if (observed === expected) numPass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic rv, input reqflit_t rf, input logic sv,
                               input rspflit_t sf, input logic ordy, input logic pf);
    req_valid = rv;
    req_flit  = rf;
    rsp_valid = sv;
    rsp_flit  = sf;
    out_ready = ordy;
    pocq_full = pf;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    rq_a = '{txn_id: 8'h11, opcode: 6'h05, addr: 16'h1234, ExpCompAck: 1'b0};
    rq_b = '{txn_id: 8'h22, opcode: 6'h09, addr: 16'hBEEF, ExpCompAck: 1'b1};
    rs_a = '{txn_id: 8'h33, opcode: 4'h3, dbid: 8'h44};
    rs_b = '{txn_id: 8'h55, opcode: 4'h7, dbid: 8'h66};

    // Reset held three cycles with both sources valid
    reset = 1'b1;
    applyStimulus(1'b1, rq_a, 1'b1, rs_a, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_readies", 64'({req_ready, rsp_ready}), 64'd0);
      checkOutput("rst_cnts", 64'({grant_cnt_req, grant_cnt_rsp}), 64'd0);
    end
    checkOutput("rst_out_req", 64'(out_req), 64'd0);
    checkOutput("rst_out_rsp", 64'(out_rsp), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rel_readies", 64'({req_ready, rsp_ready}), 64'b01);
    tick();
    checkOutput("rel_out_valid", 64'(out_valid), 64'd1);
    checkOutput("rel_out_sel", 64'(out_sel), 64'd1);
    checkOutput("rel_out_rsp", 64'(out_rsp), 64'(rs_a));

    // Response priority with starvation relief every fifth grant
    doReset();
    applyStimulus(1'b1, rq_a, 1'b1, rs_a, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("starve_rdy_%0d", k), 64'({req_ready, rsp_ready}),
                  (k % 5 == 4) ? 64'b10 : 64'b01);
      tick();
      checkOutput($sformatf("starve_sel_%0d", k), 64'(out_sel), (k % 5 == 4) ? 64'd0 : 64'd1);
      checkOutput($sformatf("starve_cnt_%0d", k), 64'(dut.starve_cnt),
                  (k % 5 == 4) ? 64'd0 : 64'(k % 5 + 1));
    end
    checkOutput("starve_gnt_rsp", 64'(grant_cnt_rsp), 64'd16);
    checkOutput("starve_gnt_req", 64'(grant_cnt_req), 64'd4);

    // POCQ full masks only ExpCompAck requests
    doReset();
    applyStimulus(1'b1, rq_b, 1'b0, rs_a, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("pocq_req_ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("pocq_starve", 64'(dut.starve_cnt), 64'd0);
      checkOutput("pocq_out_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(1'b1, rq_a, 1'b0, rs_a, 1'b1, 1'b1);
    checkOutput("pocq_noack_ready", 64'(req_ready), 64'd1);
    tick();
    checkOutput("pocq_noack_sel", 64'(out_sel), 64'd0);
    checkOutput("pocq_noack_req", 64'(out_req), 64'(rq_a));
    applyStimulus(1'b0, rq_b, 1'b1, rs_b, 1'b1, 1'b1);
    checkOutput("pocq_rsp_ready", 64'(rsp_ready), 64'd1);

    // Back-pressure holds the issue register and the starvation count
    doReset();
    applyStimulus(1'b1, rq_a, 1'b1, rs_a, 1'b0, 1'b0);
    checkOutput("bp_first_rdy", 64'({req_ready, rsp_ready}), 64'b01);
    tick();
    applyStimulus(1'b1, rq_a, 1'b1, rs_b, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_readies", 64'({req_ready, rsp_ready}), 64'd0);
      tick();
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_rsp", 64'({out_sel, out_rsp}), 64'({1'b1, rs_a}));
      checkOutput("bp_starve", 64'(dut.starve_cnt), 64'd1);
    end
    checkOutput("bp_gnt_cnts", 64'({grant_cnt_req, grant_cnt_rsp}), 64'({16'd0, 16'd1}));
    applyStimulus(1'b1, rq_a, 1'b1, rs_b, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp_rel_rdy_%0d", k), 64'({req_ready, rsp_ready}),
                  (k == 3) ? 64'b10 : 64'b01);
      tick();
      checkOutput($sformatf("bp_rel_valid_%0d", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_rel_sel_%0d", k), 64'(out_sel), (k == 3) ? 64'd0 : 64'd1);
    end
    checkOutput("bp_rel_rsp", 64'(out_rsp), 64'(rs_b));

    // Alternating single requests at full throughput
    doReset();
    for (int k = 0; k < 8; k++) begin
      rq_b = '{txn_id: 8'(k + 8'h40), opcode: 6'(k), addr: 16'(k * 16'h0101), ExpCompAck: 1'b0};
      applyStimulus(k % 2 == 0, rq_b, 1'b0, rs_a, 1'b1, 1'b0);
      checkOutput($sformatf("thr_ready_%0d", k), 64'(req_ready), 64'(k % 2 == 0));
      tick();
      checkOutput($sformatf("thr_valid_%0d", k), 64'(out_valid), 64'(k % 2 == 0));
      if (k % 2 == 0) checkOutput($sformatf("thr_req_%0d", k), 64'(out_req), 64'(rq_b));
    end

    // Counter wrap on the 4-bit instance, then reset mid-operation
    doReset();
    applyStimulus(1'b1, rq_a, 1'b0, rs_a, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    checkOutput("wrap_cnt16", 64'(grant_cnt_req), 64'd17);
    checkOutput("wrap_cnt4", 64'(n_cnt_req), 64'd1);
    checkOutput("wrap_cnt4_rsp", 64'(n_cnt_rsp), 64'd0);
    checkOutput("mid_valid_before", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_cnt", 64'(grant_cnt_req), 64'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
